reaction_game_ctrl: RTL

Game-sequencing controller for the FPGA reaction-time game. It owns the game state machine: mode selection, a pseudo-random hold-off delay, millisecond reaction timing, and result/foul handling. It drives the select, mode and number inputs of the 4-digit seven-segment display driver, plus the "go" LED. All button inputs arrive already debounced and synchronized to clk_500Hz as single-cycle pulses.

---
 rtl/reaction_game_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game sequencer: mode select, LFSR hold-off, ms reaction timing,
// result/foul handling; drives the seven-segment driver controls and the go LED.
module reaction_game_ctrl #(
  parameter int unsigned DELAY_MIN_TICKS = 250,
  parameter logic [9:0]  LFSR_SEED       = 10'h2A5
) (
  input  logic        clk_500Hz,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_react,
  input  logic        btn_mode,
  output logic [1:0]  select,
  output logic [1:0]  mode,
  output logic [13:0] number,
  output logic        led_go
);

  localparam int unsigned NUM_W  = 14;
  localparam int unsigned LFSR_W = 10;
  localparam int unsigned DLY_W  = 16;

  localparam logic [1:0] SEL_MENU   = 2'd0;
  localparam logic [1:0] SEL_WAIT   = 2'd1;
  localparam logic [1:0] SEL_RESULT = 2'd2;
  localparam logic [1:0] SEL_FOUL   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GO,
    S_RESULT,
    S_FOUL
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_d;
  logic [NUM_W-1:0]   number_d;
  logic [DLY_W-1:0]   delay_q, delay_d;
  logic [LFSR_W-1:0]  lfsr_q;
  logic [NUM_W-1:0]   limit_c;
  logic [1:0]         select_d;
  logic               led_go_d;

  // Free-running x^10+x^7+1 Fibonacci LFSR; its phase at btn_start sets the hold-off.
  always_ff @(posedge clk_500Hz or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
  end

  // Timeout in ms for the current difficulty.
  always_comb begin
    limit_c = NUM_W'(1000);
    case (mode)
      2'b00:   limit_c = NUM_W'(2000);
      2'b01:   limit_c = NUM_W'(1000);
      2'b10:   limit_c = NUM_W'(500);
      default: limit_c = NUM_W'(1000);
    endcase
  end

  always_ff @(posedge clk_500Hz or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode    <= 2'b00;
      number  <= '0;
      delay_q <= '0;
      select  <= SEL_MENU;
      led_go  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode    <= mode_d;
      number  <= number_d;
      delay_q <= delay_d;
      select  <= select_d;
      led_go  <= led_go_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode;
    number_d = number;
    delay_d  = delay_q;
    select_d = SEL_MENU;
    led_go_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (btn_start) begin
          delay_d  = DLY_W'(DELAY_MIN_TICKS) + DLY_W'(lfsr_q[8:0]);
          number_d = '0;
          state_d  = S_WAIT;
        end else if (btn_mode) begin
          mode_d = (mode == 2'b10) ? 2'b00 : mode + 2'b01;
        end
      end
      S_WAIT: begin
        // An early press takes priority over the hold-off expiring.
        if (btn_react) begin
          number_d = '0;
          state_d  = S_FOUL;
        end else if (delay_q <= DLY_W'(1)) begin
          delay_d  = '0;
          number_d = '0;
          state_d  = S_GO;
        end else begin
          delay_d = delay_q - DLY_W'(1);
        end
      end
      S_GO: begin
        if (btn_react) begin
          state_d = S_RESULT;
        end else if (number == limit_c) begin
          state_d = S_FOUL;
        end else begin
          number_d = number + NUM_W'(2);
        end
      end
      S_RESULT, S_FOUL: begin
        if (btn_start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Display controls are registered from the next state so they track state_q.
    case (state_d)
      S_IDLE:   select_d = SEL_MENU;
      S_WAIT:   select_d = SEL_WAIT;
      S_GO:     select_d = SEL_WAIT;
      S_RESULT: select_d = SEL_RESULT;
      S_FOUL:   select_d = SEL_FOUL;
      default:  select_d = SEL_MENU;
    endcase
    led_go_d = (state_d == S_GO);
  end

endmodule
